// File: rtl/vppm_frame_sync_pkg.sv
// Shared definitions for the VPPM receive path: frame FSM states, frame error codes
// and the popcount helper used by the sync correlator.
package vppm_frame_sync_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } fsmState_t;

    typedef enum logic [1:0] {
        ERR_OK  = 2'd0,
        ERR_CHK = 2'd1,
        ERR_LEN = 2'd2,
        ERR_TMO = 2'd3
    } errCode_t;

    function automatic logic [4:0] popCount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_correlator.sv
// Sliding 16-bit sync correlator: shifts in every qualified bit and flags a match
// when the freshly shifted window is within SYNC_TOL bit errors of SYNC_WORD.
module sync_correlator
    import vppm_frame_sync_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = 16'hA5C3,
    parameter int unsigned SYNC_TOL  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bitIn,
    input  logic bitValid,
    input  logic clear,
    output logic match
);

    logic [15:0] shiftReg;
    logic [15:0] shiftNext;
    logic [4:0]  fillCnt;

    assign shiftNext = {shiftReg[14:0], bitIn};

    // A clear also drops a coincident bit: that bit still belongs to the frame being closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftReg <= '0;
            fillCnt  <= '0;
        end else if (clear) begin
            shiftReg <= '0;
            fillCnt  <= '0;
        end else if (bitValid) begin
            shiftReg <= shiftNext;
            if (fillCnt != 5'd16) begin
                fillCnt <= fillCnt + 5'd1;
            end
        end
    end

    assign match = bitValid && (fillCnt >= 5'd15) &&
                   (32'(popCount16(shiftNext ^ SYNC_WORD)) <= SYNC_TOL);

endmodule

// File: rtl/vppm_frame_sync.sv
// VPPM frame synchroniser: hunts for the sync word, then assembles LEN | PAYLOAD | CHK
// frames, streams payload bytes and reports frame status on frame_end.
module vppm_frame_sync
    import vppm_frame_sync_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = 16'hA5C3,
    parameter int unsigned SYNC_TOL  = 1,
    parameter int unsigned MAX_LEN   = 64,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_ok,
    output logic [1:0] err_code,
    output logic       locked
);

    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    // Timer holds (cycles since last strobe - 1); abort is registered so frame_end lands TIMEOUT clks after the strobe.
    localparam logic [12:0] TMO_LAST  = 13'(TIMEOUT - 2);

    fsmState_t  state, stateNext;
    errCode_t   errReg, errNext, endErr;
    logic [2:0] bitCnt, bitCntNext;
    logic [7:0] byteSr, byteSrNext;
    logic [7:0] acc, accNext;
    logic [7:0] remaining, remainingNext;
    logic [7:0] byteOutNext;
    logic [7:0] newByte;
    logic [12:0] timer, timerNext;
    logic       firstByte, firstByteNext;
    logic       byteValidNext, frameStartNext, frameEndNext, frameOkNext, lockedNext;
    logic       syncMatch, byteDone, timeoutHit, endFrame;

    sync_correlator #(
        .SYNC_WORD(SYNC_WORD),
        .SYNC_TOL (SYNC_TOL)
    ) uCorr (
        .clk     (clk),
        .rst_n   (rst_n),
        .bitIn   (bit_in),
        .bitValid(bit_valid),
        .clear   (endFrame),
        .match   (syncMatch)
    );

    assign newByte    = {byteSr[6:0], bit_in};
    assign byteDone   = bit_valid && (bitCnt == 3'd7);
    assign timeoutHit = (state != HUNT) && !bit_valid && (timer == TMO_LAST);
    assign err_code   = errReg;

    always_comb begin
        stateNext      = state;
        bitCntNext     = bitCnt;
        byteSrNext     = byteSr;
        accNext        = acc;
        remainingNext  = remaining;
        firstByteNext  = firstByte;
        timerNext      = '0;
        byteOutNext    = byte_out;
        byteValidNext  = 1'b0;
        frameStartNext = 1'b0;
        frameEndNext   = 1'b0;
        frameOkNext    = frame_ok;
        errNext        = errReg;
        lockedNext     = locked;
        endFrame       = 1'b0;
        endErr         = ERR_OK;

        if (bit_valid) begin
            byteSrNext = newByte;
        end
        if (state != HUNT) begin
            timerNext = bit_valid ? '0 : timer + 13'd1;
            if (bit_valid) begin
                bitCntNext = bitCnt + 3'd1;
            end
        end

        if (timeoutHit) begin
            endFrame = 1'b1;
            endErr   = ERR_TMO;
        end else begin
            case (state)
                HUNT: begin
                    bitCntNext = '0;
                    if (syncMatch) begin
                        stateNext  = LEN;
                        lockedNext = 1'b1;
                    end
                end
                LEN: begin
                    if (byteDone) begin
                        if (newByte > MAX_LEN_B) begin
                            endFrame = 1'b1;
                            endErr   = ERR_LEN;
                        end else if (newByte == 8'd0) begin
                            accNext   = '0;
                            stateNext = CHK;
                        end else begin
                            accNext       = newByte;
                            remainingNext = newByte;
                            firstByteNext = 1'b1;
                            stateNext     = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (byteDone) begin
                        byteOutNext    = newByte;
                        byteValidNext  = 1'b1;
                        frameStartNext = firstByte;
                        firstByteNext  = 1'b0;
                        accNext        = acc + newByte;
                        remainingNext  = remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            stateNext = CHK;
                        end
                    end
                end
                CHK: begin
                    if (byteDone) begin
                        endFrame = 1'b1;
                        endErr   = (newByte == acc) ? ERR_OK : ERR_CHK;
                    end
                end
                default: stateNext = HUNT;
            endcase
        end

        if (endFrame) begin
            stateNext    = HUNT;
            lockedNext   = 1'b0;
            frameEndNext = 1'b1;
            frameOkNext  = (endErr == ERR_OK);
            errNext      = endErr;
            timerNext    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            bitCnt      <= '0;
            byteSr      <= '0;
            acc         <= '0;
            remaining   <= '0;
            firstByte   <= 1'b0;
            timer       <= '0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_ok    <= 1'b0;
            errReg      <= ERR_OK;
            locked      <= 1'b0;
        end else begin
            state       <= stateNext;
            bitCnt      <= bitCntNext;
            byteSr      <= byteSrNext;
            acc         <= accNext;
            remaining   <= remainingNext;
            firstByte   <= firstByteNext;
            timer       <= timerNext;
            byte_out    <= byteOutNext;
            byte_valid  <= byteValidNext;
            frame_start <= frameStartNext;
            frame_end   <= frameEndNext;
            frame_ok    <= frameOkNext;
            errReg      <= errNext;
            locked      <= lockedNext;
        end
    end

endmodule

// File: tb/tb_vppm_frame_sync.sv
// Scoreboard bench for vppm_frame_sync: directed frames push expected bytes/frame ends,
// a negedge monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_vppm_frame_sync;

    localparam int TMO = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid, frame_start, frame_end, frame_ok, locked;
    logic [1:0] err_code;

    typedef struct {
        logic       isEnd;
        logic [7:0] data;
        logic       start;
        logic       ok;
        logic [1:0] err;
        int         cyc;
    } exp_t;

    exp_t       expQ[$];
    exp_t       mon;
    logic [7:0] txQ[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         lastStrobe = 0;

    always #2.5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vppm_frame_sync #(
        .SYNC_WORD(16'hA5C3),
        .SYNC_TOL (1),
        .MAX_LEN  (64),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .frame_ok   (frame_ok),
        .err_code   (err_code),
        .locked     (locked)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pushByte(input logic [7:0] d, input logic s);
        exp_t e;
        e.isEnd = 1'b0; e.data = d; e.start = s; e.ok = 1'b0; e.err = 2'd0; e.cyc = -1;
        expQ.push_back(e);
    endtask

    task automatic pushEnd(input logic ok, input logic [1:0] err, input int c);
        exp_t e;
        e.isEnd = 1'b1; e.data = 8'h00; e.start = 1'b0; e.ok = ok; e.err = err; e.cyc = c;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendBit(input logic b);
        bit_in = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        lastStrobe = cyc;
    endtask

    task automatic sendByte(input logic [7:0] v, input int gap);
        for (int i = 7; i >= 0; i--) begin
            sendBit(v[i]);
            idle(gap);
        end
    endtask

    task automatic sendQ(input int gap);
        foreach (txQ[i]) sendByte(txQ[i], gap);
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        check({tag, "_frame_end"}, 32'(frame_end), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_byte_out"}, 32'(byte_out), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    always @(negedge clk) begin
        if (byte_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected nothing", byte_out);
            end else begin
                mon = expQ.pop_front();
                check("event_kind_byte", 32'(mon.isEnd), 32'd0);
                check("byte_out", 32'(byte_out), 32'(mon.data));
                check("frame_start", 32'(frame_start), 32'(mon.start));
            end
        end else if (frame_start) begin
            checks++;
            errors++;
            $display("FAIL stray_frame_start: got 1 expected 0");
        end
        if (frame_end) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_end: got ok=%0b err=%0d expected nothing", frame_ok, err_code);
            end else begin
                mon = expQ.pop_front();
                check("event_kind_end", 32'(mon.isEnd), 32'd1);
                check("frame_ok", 32'(frame_ok), 32'(mon.ok));
                check("err_code", 32'(err_code), 32'(mon.err));
                if (mon.cyc >= 0) check("frame_end_cycle", 32'(cyc), 32'(mon.cyc));
            end
        end
    end

    initial begin
        idle(3);
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        idle(2);

        // 1: good frame, checksum = LEN + payload = 03+11+22+33 = 69
        pushByte(8'h11, 1'b1); pushByte(8'h22, 1'b0); pushByte(8'h33, 1'b0);
        pushEnd(1'b1, 2'd0, -1);
        txQ = {8'hA5, 8'hC3};
        sendQ(1);
        check("locked_after_sync", 32'(locked), 32'd1);
        txQ = {8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        sendQ(1);
        idle(4);
        check("locked_after_end", 32'(locked), 32'd0);

        // 2: checksum mismatch (66 would be payload-only sum)
        pushByte(8'h11, 1'b1); pushByte(8'h22, 1'b0); pushByte(8'h33, 1'b0);
        pushEnd(1'b0, 2'd1, -1);
        txQ = {8'hA5, 8'hC3, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        sendQ(1);
        idle(4);

        // 3: one-bit sync error locks, two-bit error does not
        pushByte(8'h11, 1'b1); pushByte(8'h22, 1'b0); pushByte(8'h33, 1'b0);
        pushEnd(1'b1, 2'd0, -1);
        txQ = {8'hA5, 8'hC2, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        sendQ(1);
        idle(4);
        txQ = {8'hA5, 8'hC0};
        sendQ(1);
        check("no_lock_two_flips", 32'(locked), 32'd0);
        txQ = {8'h00, 8'h00};
        sendQ(1);
        check("no_lock_after_pad", 32'(locked), 32'd0);

        // 4: oversize LEN aborts, zero LEN with zero CHK is ok
        pushEnd(1'b0, 2'd2, -1);
        txQ = {8'hA5, 8'hC3, 8'h50};
        sendQ(1);
        idle(4);
        check("locked_after_len_abort", 32'(locked), 32'd0);
        pushEnd(1'b1, 2'd0, -1);
        txQ = {8'hA5, 8'hC3, 8'h00, 8'h00};
        sendQ(1);
        idle(4);

        // 5: strobe on the expiry cycle saves the frame, then a real timeout
        pushByte(8'h11, 1'b1); pushByte(8'h22, 1'b0);
        txQ = {8'hA5, 8'hC3, 8'h03, 8'h11, 8'h22};
        sendQ(1);
        idle(lastStrobe + TMO - 2 - cyc);
        sendBit(1'b0);
        pushEnd(1'b0, 2'd3, lastStrobe + TMO - 1);
        idle(TMO + 8);
        check("locked_after_timeout", 32'(locked), 32'd0);

        // 6: reset mid-payload, then two back-to-back frames at 1 bit/clk
        pushByte(8'h11, 1'b1);
        txQ = {8'hA5, 8'hC3, 8'h03, 8'h11};
        sendQ(1);
        sendBit(1'b0); sendBit(1'b0); sendBit(1'b1); sendBit(1'b0);
        rst_n = 1'b0;
        idle(2);
        checkIdleOutputs("midreset");
        rst_n = 1'b1;
        idle(2);
        pushByte(8'h11, 1'b1); pushByte(8'h22, 1'b0); pushByte(8'h33, 1'b0);
        pushEnd(1'b1, 2'd0, -1);
        pushByte(8'hAA, 1'b1); pushByte(8'h55, 1'b0);
        pushEnd(1'b1, 2'd0, -1);
        txQ = {8'hA5, 8'hC3, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69,
               8'hA5, 8'hC3, 8'h02, 8'hAA, 8'h55, 8'h01};
        sendQ(0);
        idle(20);

        check("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
